// File: rtl/data_mem_unit.sv
// ============================================================================
// data_mem_unit : RV32 data memory with byte lanes, split misaligned beats and
//                 an error flag for illegal/out-of-range accesses. Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 32768,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESP  = 2'd1;
  localparam logic [1:0] ST_SPLIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  // Context carried from beat 1 to beat 2 of a misaligned access
  logic [2:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [IDX_W-1:0] nidx_q, nidx_d;
  logic             we_q, we_d;
  logic [31:0]      hi_wdata_q, hi_wdata_d;
  logic [3:0]       hi_mask_q, hi_mask_d;
  logic [31:0]      lo_word_q, lo_word_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic                  accept;
  logic [ADDR_WIDTH-3:0] word_full;
  logic [1:0]            off;
  logic [IDX_W-1:0]      idx;
  logic                  op_legal;
  logic                  misal;
  logic                  out_of_range;
  logic                  last_word;
  logic                  err;
  logic [3:0]            size_mask;
  logic [7:0]            lane_mask8;
  logic [63:0]           wdata64;
  logic [IDX_W-1:0]      rd_idx;
  logic [31:0]           rd_word;
  logic [31:0]           aligned_data;
  logic [31:0]           split_data;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd4:    extend = {24'b0, d[7:0]};
      3'd5:    extend = {16'b0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign req_ready  = !rst && (state_q != ST_SPLIT);
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign word_full = req_addr[ADDR_WIDTH-1:2];
  assign off       = req_addr[1:0];
  assign idx       = req_addr[IDX_W+1:2];

  always_comb begin
    size_mask = 4'b1111;
    case (req_op[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign op_legal = (req_op == 3'd0 || req_op == 3'd1 || req_op == 3'd2 ||
                     req_op == 3'd4 || req_op == 3'd5) && !(req_we && req_op[2]);
  assign misal    = (req_op[1:0] == 2'd1 && off == 2'd3) ||
                    (req_op[1:0] == 2'd2 && off != 2'd0);
  assign out_of_range = word_full >= (ADDR_WIDTH-2)'(DEPTH_WORDS);
  // A misaligned access starting in the last word would need a word past the end
  assign last_word    = word_full >= (ADDR_WIDTH-2)'(DEPTH_WORDS - 1);
  assign err = !op_legal || out_of_range || (misal && (!MISALIGN_EN || last_word));

  assign lane_mask8 = {4'b0000, size_mask} << off;
  assign wdata64    = {32'b0, req_wdata} << {off, 3'b000};

  assign rd_idx       = (state_q == ST_SPLIT) ? nidx_q : idx;
  assign rd_word      = mem_q[rd_idx];
  assign aligned_data = extend(req_op, rd_word >> {off, 3'b000});
  assign split_data   = extend(op_q, 32'({rd_word, lo_word_q} >> {off_q, 3'b000}));

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    op_d         = op_q;
    off_d        = off_q;
    nidx_d       = nidx_q;
    we_d         = we_q;
    hi_wdata_d   = hi_wdata_q;
    hi_mask_d    = hi_mask_q;
    lo_word_d    = lo_word_q;
    mem_we       = 1'b0;
    mem_widx     = idx;
    mem_wmask    = lane_mask8[3:0];
    mem_wdata    = wdata64[31:0];

    if (state_q == ST_SPLIT) begin
      mem_we       = we_q;
      mem_widx     = nidx_q;
      mem_wmask    = hi_mask_q;
      mem_wdata    = hi_wdata_q;
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b0;
      resp_rdata_d = we_q ? 32'b0 : split_data;
      state_d      = ST_RESP;
    end else if (accept) begin
      if (err) begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = 32'b0;
        state_d      = ST_RESP;
      end else begin
        mem_we = req_we;
        if (misal) begin
          op_d       = req_op;
          off_d      = off;
          nidx_d     = idx + 1'b1;
          we_d       = req_we;
          hi_wdata_d = wdata64[63:32];
          hi_mask_d  = lane_mask8[7:4];
          lo_word_d  = rd_word;
          state_d    = ST_SPLIT;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = req_we ? 32'b0 : aligned_data;
          state_d      = ST_RESP;
        end
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
      op_q         <= 3'b0;
      off_q        <= 2'b0;
      nidx_q       <= '0;
      we_q         <= 1'b0;
      hi_wdata_q   <= 32'b0;
      hi_mask_q    <= 4'b0;
      lo_word_q    <= 32'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      op_q         <= op_d;
      off_q        <= off_d;
      nidx_q       <= nidx_d;
      we_q         <= we_d;
      hi_wdata_q   <= hi_wdata_d;
      hi_mask_q    <= hi_mask_d;
      lo_word_q    <= lo_word_d;
    end
  end

  // Array has no reset; a reset during SPLIT clears state_q, which gates off beat 2
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Next-generation data memory for the RV32 core: single-clock, valid/ready request port, registered response, on-chip word array of parametrised depth.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW with byte-lane masking and sign/zero extension.
- New over the previous memory: misaligned halfword/word accesses are split into two word beats by an FSM, and out-of-range or illegal accesses return an error flag.
- Sits between the LSU and the on-chip array.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 32768, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = flag them as errors.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU; stores use 0/1/2 only.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle pulse: response/ack.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: access rejected.

Behaviour:
- Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0 while rst is high. Array contents are not reset.
- Handshake: a request is accepted on a rising edge with req_valid&&req_ready. All request fields are sampled only at acceptance. No response backpressure.
- req_ready=1 in IDLE and RESP; 0 in SPLIT.
- Legal access: op in {0,1,2,4,5}; stores additionally limited to {0,1,2}.
- Size: 1/2/4 bytes; offset = addr[1:0].
- Misaligned means offset+size>4. Only H at offset 3 and W at offsets 1-3 qualify.
- Error, decided at accept: any of the following gives resp_err=1, no array write, resp_valid at T+1.
  - Illegal op.
  - Word index addr>>2 >= DEPTH_WORDS.
  - Misaligned with MISALIGN_EN=0.
  - Misaligned whose second word index >= DEPTH_WORDS; this covers the last-word wrap, and neither beat is written.
- Aligned access accepted at edge T:
  - Store writes lanes wmask=((1<<size)-1)<<offset with data shifted left by 8*offset, at edge T.
  - Load reads the word at edge T.
  - resp_valid=1 in cycle T+1. FSM: IDLE->RESP->IDLE, or RESP->RESP on back-to-back requests.
- Misaligned access accepted at edge T (MISALIGN_EN=1):
  - Beat 1, word w, at edge T: lanes offset..3.
  - State SPLIT. Beat 2, word w+1, at edge T+1: lanes 0..(offset+size-5).
  - resp_valid in cycle T+2.
- Load assembly: concatenate {word(w+1), word(w)} into 64 bits, shift right by 8*offset, take the low size bytes, then extend.
- Extension: sign-extend for ops 0/1; zero-extend for ops 4/5; no extension for W.
- Ordering: one array access per cycle. A store accepted at T is visible to a load accepted at T+1 (read-after-write, no stale data).
- Throughput: aligned accesses sustain one per cycle; misaligned accesses take 2 cycles.
- Reset during SPLIT: return to IDLE with no response. A store's beat-1 bytes stay written; beat 2 is dropped.
- resp_rdata and resp_err are held at their last values when resp_valid=0; testbenches must qualify them with resp_valid.

Test Plan:
- Aligned SW 0xDEADBEEF @0x100, then LW @0x100 back-to-back -> resp_valid at T+1 and T+2; second resp_rdata=0xDEADBEEF, resp_err=0.
- After the previous step, SB 0x80 @0x101; then LB @0x101 -> 0xFFFFFF80; LBU @0x101 -> 0x00000080; LW @0x100 -> 0xDEAD80EF.
- Misaligned access:
  - Setup: SW 0x44332211 @0x200, SW 0x88776655 @0x204.
  - LW @0x203 -> req_ready low for 1 cycle, resp at T+2, rdata=0x77665544.
  - LH @0x203 -> 0x00005544.
- Misaligned SW 0xAABBCCDD @0x206 -> words 0x204=0xCCDD6655 and 0x208 low half=0xAABB, verified by read-back.
- Error cases:
  - LW @4*DEPTH_WORDS -> resp_err=1, rdata=0.
  - LW @4*DEPTH_WORDS-2 -> err, no write.
  - req_op=3 -> err.
  - MISALIGN_EN=0 build, LW @0x201 -> err at T+1, memory unchanged.
- Assert rst during SPLIT of a misaligned SW @0x206 -> no resp_valid, req_ready=0 while reset is held, then 1; beat-1 bytes written, word 0x208 unchanged.
